// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline front-end controller.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned CTRL_W_DEF   = 12;
    localparam int unsigned REG_W        = 5;

    // Saturating 32-bit increment used by the performance counters.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
        return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/pipe_front_ctrl_if.sv
// Hazard/fetch/decode bundle seen by pipe_front_ctrl; master drives hazard and stage inputs.
interface pipe_front_ctrl_if #(
    parameter int unsigned CTRL_W = pipe_pkg::CTRL_W_DEF
);

    logic              StallF;
    logic              StallD;
    logic              FlushD;
    logic              FlushE;
    logic              PCSrcD;
    logic [31:0]       PCBranchD;
    logic              JumpD;
    logic [31:0]       PCJumpD;
    logic [31:0]       InstrF;
    logic [CTRL_W-1:0] CtrlD;
    logic [4:0]        RsD;
    logic [4:0]        RtD;
    logic [4:0]        RdD;

    logic [31:0]       PCF;
    logic [31:0]       InstrD;
    logic [31:0]       PCPlus4D;
    logic              ValidD;
    logic [CTRL_W-1:0] CtrlE;
    logic [4:0]        RsE;
    logic [4:0]        RtE;
    logic [4:0]        RdE;
    logic              ValidE;
    logic [31:0]       StallCycles;
    logic [31:0]       BubbleCycles;
    logic              StallErr;

    modport master (
        output StallF, StallD, FlushD, FlushE, PCSrcD, PCBranchD, JumpD, PCJumpD,
               InstrF, CtrlD, RsD, RtD, RdD,
        input  PCF, InstrD, PCPlus4D, ValidD, CtrlE, RsE, RtE, RdE, ValidE,
               StallCycles, BubbleCycles, StallErr
    );

    modport slave (
        input  StallF, StallD, FlushD, FlushE, PCSrcD, PCBranchD, JumpD, PCJumpD,
               InstrF, CtrlD, RsD, RtD, RdD,
        output PCF, InstrD, PCPlus4D, ValidD, CtrlE, RsE, RtE, RdE, ValidE,
               StallCycles, BubbleCycles, StallErr
    );

endinterface

// File: rtl/pipe_reg.sv
// Generic pipeline register: synchronous reset, clear has priority over load enable.
module pipe_reg #(
    parameter int unsigned      Width  = 32,
    parameter logic [Width-1:0] RstVal = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RstVal;
        end else if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/pipe_front_ctrl.sv
// Applies stall/flush to PC, IF/ID and ID/EX, selects next PC, and (with PIPE_PERF_CNT_EN)
// keeps stall/bubble counters plus a sticky stall-deadlock watchdog.
module pipe_front_ctrl
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter int unsigned CTRL_W      = CTRL_W_DEF,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    pipe_front_ctrl_if.slave  bus
);

    localparam int unsigned IfIdW = 32 + 32 + 1;
    localparam int unsigned IdExW = CTRL_W + 3 * REG_W + 1;

    logic [31:0]      pc_q;
    logic [31:0]      pc_d;
    logic [31:0]      pc_plus4;
    logic [IfIdW-1:0] ifid_q;
    logic [IdExW-1:0] idex_q;

    assign pc_plus4 = pc_q + PC_STEP;

    // Jump outranks branch; the PC register itself ignores pc_d while StallF holds it.
    always_comb begin
        pc_d = pc_plus4;
        if (bus.JumpD) begin
            pc_d = bus.PCJumpD;
        end else if (bus.PCSrcD) begin
            pc_d = bus.PCBranchD;
        end
    end

    pipe_reg #(
        .Width  (32),
        .RstVal (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (~bus.StallF),
        .clr_i (1'b0),
        .d_i   (pc_d),
        .q_o   (pc_q)
    );

    // Clearing to zero yields NOP_INSTR, PCPlus4D=0 and ValidD=0.
    pipe_reg #(
        .Width  (IfIdW),
        .RstVal ('0)
    ) u_ifid_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (~bus.StallD),
        .clr_i (bus.FlushD & ~bus.StallD),
        .d_i   ({bus.InstrF, pc_plus4, 1'b1}),
        .q_o   (ifid_q)
    );

    pipe_reg #(
        .Width  (IdExW),
        .RstVal ('0)
    ) u_idex_reg (
        .clk   (clk),
        .rst   (rst),
        .en_i  (1'b1),
        .clr_i (bus.FlushE),
        .d_i   ({bus.CtrlD, bus.RsD, bus.RtD, bus.RdD, ifid_q[0]}),
        .q_o   (idex_q)
    );

    assign bus.PCF      = pc_q;
    assign bus.InstrD   = ifid_q[IfIdW-1 -: 32];
    assign bus.PCPlus4D = ifid_q[32:1];
    assign bus.ValidD   = ifid_q[0];
    assign bus.CtrlE    = idex_q[IdExW-1 -: CTRL_W];
    assign bus.RsE      = idex_q[3*REG_W:2*REG_W+1];
    assign bus.RtE      = idex_q[2*REG_W:REG_W+1];
    assign bus.RdE      = idex_q[REG_W:1];
    assign bus.ValidE   = idex_q[0];

`ifdef PIPE_PERF_CNT_EN
    localparam logic [7:0] LimitVal = 8'(STALL_LIMIT);

    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;
    logic [7:0]  run_q, run_d;
    logic        err_q, err_d;

    always_comb begin
        stall_cnt_d  = sat_inc(stall_cnt_q, bus.StallF);
        bubble_cnt_d = sat_inc(bubble_cnt_q, bus.FlushE);
        run_d        = '0;
        if (bus.StallF) begin
            run_d = (run_q == LimitVal) ? run_q : run_q + 8'd1;
        end
        err_d = err_q | (run_d == LimitVal);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            run_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            run_q        <= run_d;
            err_q        <= err_d;
        end
    end

    assign bus.StallCycles  = stall_cnt_q;
    assign bus.BubbleCycles = bubble_cnt_q;
    assign bus.StallErr     = err_q;
`else
    assign bus.StallCycles  = '0;
    assign bus.BubbleCycles = '0;
    assign bus.StallErr     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Self-checking bench for pipe_front_ctrl: directed plan steps followed by random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_front_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CTRL_W   = 12;
    localparam int          LIMIT    = 16;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_front_ctrl_if #(.CTRL_W(CTRL_W)) bus ();

    pipe_front_ctrl #(
        .RESET_PC    (RESET_PC),
        .CTRL_W      (CTRL_W),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state.
    logic [31:0]       m_pc = 0, m_instr_d = 0, m_pcp4_d = 0;
    logic              m_valid_d = 0, m_valid_e = 0, m_err = 0;
    logic [CTRL_W-1:0] m_ctrl_e = 0;
    logic [4:0]        m_rs_e = 0, m_rt_e = 0, m_rd_e = 0;
    longint            m_stall = 0, m_bub = 0, m_run = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'sh0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_step();
        logic [31:0] pc_n, instr_n, pcp4_n;
        logic        vd_n;
        if (rst) begin
            m_pc = RESET_PC; m_instr_d = 0; m_pcp4_d = 0; m_valid_d = 0;
            m_ctrl_e = 0; m_rs_e = 0; m_rt_e = 0; m_rd_e = 0; m_valid_e = 0;
            m_stall = 0; m_bub = 0; m_run = 0; m_err = 0;
            return;
        end
        if (bus.StallF)     pc_n = m_pc;
        else if (bus.JumpD)  pc_n = bus.PCJumpD;
        else if (bus.PCSrcD) pc_n = bus.PCBranchD;
        else                 pc_n = m_pc + 32'd4;
        if (bus.StallD) begin
            instr_n = m_instr_d; pcp4_n = m_pcp4_d; vd_n = m_valid_d;
        end else if (bus.FlushD) begin
            instr_n = 0; pcp4_n = 0; vd_n = 0;
        end else begin
            instr_n = bus.InstrF; pcp4_n = m_pc + 32'd4; vd_n = 1;
        end
        if (bus.FlushE) begin
            m_ctrl_e = 0; m_rs_e = 0; m_rt_e = 0; m_rd_e = 0; m_valid_e = 0;
        end else begin
            m_ctrl_e = bus.CtrlD; m_rs_e = bus.RsD; m_rt_e = bus.RtD; m_rd_e = bus.RdD;
            m_valid_e = m_valid_d;
        end
        m_pc = pc_n; m_instr_d = instr_n; m_pcp4_d = pcp4_n; m_valid_d = vd_n;
        m_stall += longint'(bus.StallF);
        m_bub   += longint'(bus.FlushE);
        m_run    = bus.StallF ? m_run + 1 : 0;
        if (m_run >= LIMIT) m_err = 1'b1;
    endtask

    task automatic check_all();
        chk("PCF",      bus.PCF,      m_pc);
        chk("InstrD",   bus.InstrD,   m_instr_d);
        chk("PCPlus4D", bus.PCPlus4D, m_pcp4_d);
        chk("ValidD",   {31'b0, bus.ValidD}, {31'b0, m_valid_d});
        chk("CtrlE",    {20'b0, bus.CtrlE},  {20'b0, m_ctrl_e});
        chk("RegsE",    {17'b0, bus.RsE, bus.RtE, bus.RdE}, {17'b0, m_rs_e, m_rt_e, m_rd_e});
        chk("ValidE",   {31'b0, bus.ValidE}, {31'b0, m_valid_e});
        chk("StallCycles",  bus.StallCycles,  PerfEn ? sat32(m_stall) : 32'h0);
        chk("BubbleCycles", bus.BubbleCycles, PerfEn ? sat32(m_bub) : 32'h0);
        chk("StallErr", {31'b0, bus.StallErr}, {31'b0, PerfEn & m_err});
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0;
        bus.PCSrcD = 0; bus.JumpD = 0; bus.PCBranchD = 0; bus.PCJumpD = 0;
    endtask

    initial begin
        idle();
        bus.InstrF = 0; bus.CtrlD = 0; bus.RsD = 0; bus.RtD = 0; bus.RdD = 0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pcf", bus.PCF, RESET_PC);

        // Free-running fetch.
        for (int i = 0; i < 4; i++) begin
            bus.InstrF = 32'h2008_0001 + i;
            bus.CtrlD  = CTRL_W'($urandom_range(1, 4095));
            bus.RsD = 5'($urandom); bus.RtD = 5'($urandom); bus.RdD = 5'($urandom);
            tick();
            chk("free_pcf", bus.PCF, 32'(4 * (i + 1)));
        end
        chk("free_instrd", bus.InstrD, 32'h2008_0004);

        // Load-use: D holds, E bubbles.
        bus.StallF = 1; bus.StallD = 1; bus.FlushE = 1;
        tick();
        chk("lu_pcf", bus.PCF, 32'h10);
        chk("lu_instrd", bus.InstrD, 32'h2008_0004);
        chk("lu_valide", {31'b0, bus.ValidE}, 32'h0);
        idle();

        // Branch redirect with decode flush, then jump beating branch.
        bus.PCSrcD = 1; bus.PCBranchD = 32'h40; bus.FlushD = 1;
        tick();
        chk("br_pcf", bus.PCF, 32'h40);
        chk("br_instrd", bus.InstrD, 32'h0);
        bus.JumpD = 1; bus.PCJumpD = 32'h80;
        tick();
        chk("jmp_pcf", bus.PCF, 32'h80);
        idle();

        // StallD overrides FlushD.
        bus.InstrF = 32'hABCD_0001;
        tick();
        bus.StallD = 1; bus.FlushD = 1; bus.InstrF = 32'h1111_2222;
        tick();
        chk("sd_hold", bus.InstrD, 32'hABCD_0001);
        idle();

        // PC wrap.
        bus.JumpD = 1; bus.PCJumpD = 32'hFFFF_FFFC;
        tick();
        idle();
        tick();
        chk("wrap_pcf", bus.PCF, 32'h0);

        // Watchdog: limit reached, sticky after release, then reset mid-stall.
        bus.StallF = 1; bus.StallD = 1;
        for (int i = 0; i < LIMIT; i++) tick();
        chk("wd_set", {31'b0, bus.StallErr}, {31'b0, PerfEn});
        idle();
        for (int i = 0; i < 3; i++) tick();
        chk("wd_sticky", {31'b0, bus.StallErr}, {31'b0, PerfEn});
        bus.StallF = 1; bus.FlushE = 1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_stall_cnt", bus.StallCycles, 32'h0);
        idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            bus.StallF = ($urandom_range(0, 3) == 0);
            bus.StallD = bus.StallF | ($urandom_range(0, 9) == 0);
            bus.FlushD = ($urandom_range(0, 5) == 0);
            bus.FlushE = ($urandom_range(0, 5) == 0);
            bus.PCSrcD = ($urandom_range(0, 7) == 0);
            bus.JumpD  = ($urandom_range(0, 9) == 0);
            bus.PCBranchD = {$urandom} & 32'hFFFF_FFFC;
            bus.PCJumpD   = {$urandom} & 32'hFFFF_FFFC;
            bus.InstrF    = $urandom;
            bus.CtrlD     = CTRL_W'($urandom);
            bus.RsD = 5'($urandom); bus.RtD = 5'($urandom); bus.RdD = 5'($urandom);
            tick();
        end
        rst = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
